q_mac: RTL and testbench

Streaming fixed-point multiply-accumulate stage that computes the saturating dot product of a vector of operand pairs and emits one result per vector. Sits directly upstream of the accumulation path: it multiplies and rescales each pair, then feeds the product and the running sum into a `q_add` instance every cycle. Input and output use valid/ready handshakes. Used by the vector datapath to reduce complex-amplitude rows to one fixed-point scalar.

---
 rtl/q_pkg.sv | 20 ++
 rtl/q_add.sv | 24 ++
 rtl/q_mac.sv | 135 +++++++++++++
 tb/tb_q_mac.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/q_pkg.sv
// rtl/q_pkg.sv - shared fixed-point types, limits and q_mac state encoding
package q_pkg;

  localparam int FIXED_WIDTH  = 16;
  localparam int SCALE_FACTOR = 32768;
  localparam int FRAC_BITS    = $clog2(SCALE_FACTOR);

  typedef logic signed [FIXED_WIDTH-1:0] fixed_t;

  localparam fixed_t FIXED_MAX = fixed_t'((1 << (FIXED_WIDTH - 1)) - 1);
  localparam fixed_t FIXED_MIN = fixed_t'(-(1 << (FIXED_WIDTH - 1)));

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } q_mac_state_e;

endpackage

// File: rtl/q_add.sv
// rtl/q_add.sv - saturating signed fixed-point adder with overflow flag
module q_add
  import q_pkg::*;
(
  input  logic signed [FIXED_WIDTH-1:0] a,
  input  logic signed [FIXED_WIDTH-1:0] b,
  output logic signed [FIXED_WIDTH-1:0] sum,
  output logic                          ovf
);

  logic signed [FIXED_WIDTH-1:0] raw;

  // Wrap-around sum, overflow when same-signed addends yield a sum of the other sign
  always_comb begin
    raw = a + b;
    ovf = (a[FIXED_WIDTH-1] == b[FIXED_WIDTH-1]) &&
          (raw[FIXED_WIDTH-1] != a[FIXED_WIDTH-1]);
    sum = raw;
    if (ovf) begin
      sum = a[FIXED_WIDTH-1] ? FIXED_MIN : FIXED_MAX;
    end
  end

endmodule

// File: rtl/q_mac.sv
// rtl/q_mac.sv - streaming saturating fixed-point dot product (rounding via Q_MAC_ROUND_EN)
module q_mac
  import q_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int COUNT_W = $clog2(MAX_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [FIXED_WIDTH-1:0] in_a,
  input  logic signed [FIXED_WIDTH-1:0] in_b,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [FIXED_WIDTH-1:0] out_data,
  output logic [COUNT_W-1:0]            out_count,
  output logic                          out_sat
);

  // One guard bit above the full product so the rounding offset cannot wrap
  localparam int PW = 2 * FIXED_WIDTH + 1;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  q_mac_state_e state_q, state_d;
  logic ready_q, ready_d;
  logic p1_valid_q, p1_valid_d;
  logic p1_last_q, p1_last_d;
  logic p1_sat_q, p1_sat_d;
  fixed_t p1_data_q, p1_data_d;
  fixed_t acc_q, acc_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic sat_q, sat_d;

  logic accept;
  logic signed [PW-1:0] prod_ext, prod_shift;
  fixed_t prod_clamp;
  logic prod_hit;
  fixed_t add_sum;
  logic add_ovf;

  assign accept    = in_valid && ready_q;
  assign in_ready  = ready_q;
  assign out_data  = acc_q;
  assign out_count = count_q;
  assign out_sat   = sat_q;

  // Stage-1 arithmetic: full product, optional half-up offset, rescale, clamp
  always_comb begin
    prod_ext = PW'(in_a) * PW'(in_b);
`ifdef Q_MAC_ROUND_EN
    prod_ext = prod_ext + PW'(SCALE_FACTOR / 2);
`endif
    prod_shift = prod_ext >>> FRAC_BITS;
    prod_hit   = 1'b1;
    if (prod_shift > PW'(FIXED_MAX)) begin
      prod_clamp = FIXED_MAX;
    end else if (prod_shift < PW'(FIXED_MIN)) begin
      prod_clamp = FIXED_MIN;
    end else begin
      prod_clamp = prod_shift[FIXED_WIDTH-1:0];
      prod_hit   = 1'b0;
    end
  end

  // The accumulator is already zero at vector start, so it feeds the adder directly
  q_add u_add (
    .a   (acc_q),
    .b   (p1_data_q),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // Control FSM; in_ready is registered from the next state so it never sees in_valid
  always_comb begin
    state_d   = state_q;
    out_valid = (state_q == HOLD);
    case (state_q)
      IDLE:    if (accept) state_d = in_last ? DRAIN : ACCUM;
      ACCUM:   if (accept && in_last) state_d = DRAIN;
      DRAIN:   if (p1_valid_q && p1_last_q) state_d = HOLD;
      HOLD:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) || (state_d == ACCUM);
  end

  // Datapath next values: stage-1 capture, stage-2 accumulate, clear on result handshake
  always_comb begin
    p1_valid_d = accept;
    p1_last_d  = accept && in_last;
    p1_sat_d   = accept && prod_hit;
    p1_data_d  = accept ? prod_clamp : p1_data_q;
    acc_d      = acc_q;
    count_d    = count_q;
    sat_d      = sat_q;
    if (p1_valid_q) begin
      acc_d   = add_sum;
      count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
      sat_d   = sat_q | p1_sat_q | add_ovf;
    end
    if (state_q == HOLD && out_ready) begin
      acc_d   = '0;
      count_d = '0;
      sat_d   = 1'b0;
    end
  end

  // State and pipeline registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b0;
      p1_valid_q <= 1'b0;
      p1_last_q  <= 1'b0;
      p1_sat_q   <= 1'b0;
      p1_data_q  <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      p1_valid_q <= p1_valid_d;
      p1_last_q  <= p1_last_d;
      p1_sat_q   <= p1_sat_d;
      p1_data_q  <= p1_data_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      sat_q      <= sat_d;
    end
  end

endmodule

// File: tb/tb_q_mac.sv
// tb/tb_q_mac.sv - self-checking bench for q_mac against an arithmetic dot-product model
module tb_q_mac;

  localparam int FW   = 16;
  localparam int MAXL = 6;
  localparam int CW   = $clog2(MAXL + 1);
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic signed [FW-1:0] in_a = '0;
  logic signed [FW-1:0] in_b = '0;
  logic in_last = 1'b0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic signed [FW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic out_sat;

  int checks = 0;
  int errors = 0;
  int qa[$];
  int qb[$];

  q_mac #(.MAX_LEN(MAXL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Dot product straight from the arithmetic rules: scale, clamp, saturating sum
  function automatic void model(output longint d, output longint c, output longint s);
    longint acc;
    longint p;
    acc = 0;
    s = 0;
    foreach (qa[i]) begin
      p = longint'(qa[i]) * longint'(qb[i]);
`ifdef Q_MAC_ROUND_EN
      p = p + 16384;
`endif
      p = p >>> 15;
      if (p > 32767) begin p = 32767; s = 1; end
      else if (p < -32768) begin p = -32768; s = 1; end
      acc = acc + p;
      if (acc > 32767) begin acc = 32767; s = 1; end
      else if (acc < -32768) begin acc = -32768; s = 1; end
    end
    d = acc;
    c = (qa.size() > CMAX) ? CMAX : qa.size();
  endfunction

  task automatic send_pair(input string tag, input int a, input int b, input bit last);
    bit ok;
    int g;
    in_a = FW'(a);
    in_b = FW'(b);
    in_last = last;
    in_valid = 1'b1;
    ok = 1'b0;
    g = 0;
    while (!ok && g < 20) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      g++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    chk({tag, " accept"}, ok, 1);
  endtask

  task automatic run_vec(input string tag, input bit gaps, input int hold);
    longint ed, ec, es;
    int lat;
    logic signed [FW-1:0] d0;
    logic [CW-1:0] c0;
    logic s0;
    model(ed, ec, es);
    out_ready = (hold == 0);
    for (int i = 0; i < qa.size(); i++) begin
      if (gaps && i > 0) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      send_pair(tag, qa[i], qb[i], i == qa.size() - 1);
    end
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, lat, 2);
    chk({tag, " data"}, longint'(out_data), ed);
    chk({tag, " count"}, out_count, ec);
    chk({tag, " sat"}, out_sat, es);
    chk({tag, " in_ready in hold"}, in_ready, 0);
    d0 = out_data;
    c0 = out_count;
    s0 = out_sat;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk({tag, " bp valid"}, out_valid, 1);
      chk({tag, " bp in_ready"}, in_ready, 0);
      chk({tag, " bp stable"}, {out_data, out_count, out_sat}, {d0, c0, s0});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, " post valid"}, out_valid, 0);
    chk({tag, " post in_ready"}, in_ready, 1);
  endtask

  task automatic set_vec(input int n);
    qa.delete();
    qb.delete();
    for (int i = 0; i < n; i++) begin
      qa.push_back(int'($urandom_range(0, 65535)) - 32768);
      qb.push_back(int'($urandom_range(0, 65535)) - 32768);
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", longint'(out_data), 0);
    chk("rst out_count", out_count, 0);
    chk("rst out_sat", out_sat, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("after rst in_ready", in_ready, 1);

    qa = '{16384, 16384};           qb = '{16384, 16384};   run_vec("basic", 0, 0);
    qa = '{-16384, 24576};          qb = '{8192, 16384};    run_vec("signed", 0, 0);
    qa = '{29491, 29491};           qb = '{29491, 29491};   run_vec("ovf pos", 0, 0);
    qa = '{-29491, -29491};         qb = '{29491, 29491};   run_vec("ovf neg", 0, 0);
    qa = '{-32768};                 qb = '{-32768};         run_vec("clamp", 0, 0);
    qa = '{1};                      qb = '{16384};          run_vec("round", 0, 0);
    qa = '{300, -700, 1200};        qb = '{9000, 4000, -2500}; run_vec("backpressure", 0, 5);
    qa = '{16384};                  qb = '{-16384};         run_vec("after bp", 0, 0);
    qa = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
    qb = '{2000, 2000, 2000, 2000, 2000, 2000, 2000, 2000, 2000, 2000};
    run_vec("count sat", 1, 0);

    // Reset partway through a vector discards it
    for (int i = 0; i < 3; i++) send_pair("partial", 16384, 16384, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid rst in_ready", in_ready, 0);
    chk("mid rst out_valid", out_valid, 0);
    rst = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      repeat (6) begin
        @(posedge clk);
        #1;
        seen = seen | out_valid;
      end
      chk("mid rst no output", seen, 0);
    end
    qa = '{16384}; qb = '{16384}; run_vec("after mid rst", 0, 0);

    // Random vectors with input bubbles and random backpressure
    for (int v = 0; v < 25; v++) begin
      set_vec($urandom_range(1, 9));
      run_vec($sformatf("rand%0d", v), 1, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
